// File: rtl/sobel_pkg.sv
// Shared FSM state type and runtime mode encodings for the Sobel edge-magnitude pipeline.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GRAD = 2'd1,
    SQRT = 2'd2,
    OUT  = 2'd3
  } sobel_state_t;

  localparam logic [1:0] MODE_SQRT = 2'b00;
  localparam logic [1:0] MODE_L1   = 2'b01;
  localparam logic [1:0] MODE_THR  = 2'b10;

endpackage

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root, one root bit per cycle MSB first, SQ_W/2 cycles after start.
// done pulses during the final iteration; root is the completed floor(sqrt) only while done is high.
module isqrt_seq #(
  parameter int SQ_W = 22
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [SQ_W-1:0]   radicand,
  output logic              done,
  output logic [SQ_W/2-1:0] root
);

  localparam int RT_W  = SQ_W / 2;
  localparam int CNT_W = $clog2(RT_W);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SQ_W-1:0]   rad_q;
  logic [RT_W+1:0]   rem_q;
  logic [RT_W-1:0]   root_q;

  logic [RT_W+3:0]   rem_sh;
  logic [RT_W+3:0]   trial;
  logic              take;
  logic [RT_W+1:0]   rem_nxt;
  logic [RT_W-1:0]   root_nxt;

  // Remainder stays below 2*root+1, so RT_W+2 bits hold it between iterations.
  assign rem_sh   = {rem_q, rad_q[SQ_W-1 -: 2]};
  assign trial    = {2'b00, root_q, 2'b01};
  assign take     = (rem_sh >= trial);
  assign rem_nxt  = take ? (RT_W+2)'(rem_sh - trial) : (RT_W+2)'(rem_sh);
  assign root_nxt = {root_q[RT_W-2:0], take};

  assign done = busy_q && (cnt_q == CNT_W'(RT_W - 1));
  assign root = root_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rad_q  <= radicand;
      rem_q  <= '0;
      root_q <= '0;
    end else if (busy_q) begin
      rem_q  <= rem_nxt;
      root_q <= root_nxt;
      rad_q  <= rad_q << 2;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/sobel_pipe.sv
// Sobel 3x3 edge magnitude (exact root, L1 or threshold); out_valid rises 2 (L1) / RT_W+2 cycles after the window cycle.
// One transaction in flight: in_ready only in IDLE, result held in OUT until out_ready.
module sobel_pipe
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [9*PIX_W-1:0] win,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [PIX_W-1:0]   thresh,
  output logic [PIX_W-1:0]   out_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int G_W  = PIX_W + 3;
  localparam int SQ_W = 2 * PIX_W + 6;
  localparam int RT_W = SQ_W / 2;
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  sobel_state_t        state_q;
  logic [9*PIX_W-1:0]  win_q;
  logic [1:0]          mode_q;
  logic [PIX_W-1:0]    thresh_q;
  logic [PIX_W-1:0]    out_pixel_q;

  logic signed [G_W-1:0] p [9];
  logic signed [G_W-1:0] gx, gy;
  logic [G_W-1:0]        ax, ay;
  logic [G_W:0]          l1_sum;
  logic [PIX_W-1:0]      l1_pix, root_pix, sq_pix;
  logic [SQ_W-1:0]       ax_w, ay_w, sq;
  logic                  sq_start, sq_done;
  logic [RT_W-1:0]       root;

  always_comb begin
    for (int k = 0; k < 9; k++)
      p[k] = signed'(G_W'(win_q[k*PIX_W +: PIX_W]));
  end

  // |G| <= 4*(2^PIX_W-1) < 2^(G_W-1), so the signed sums cannot wrap.
  assign gx = (p[6] + (p[7] <<< 1) + p[8]) - (p[0] + (p[1] <<< 1) + p[2]);
  assign gy = (p[2] + (p[5] <<< 1) + p[8]) - (p[0] + (p[3] <<< 1) + p[6]);
  assign ax = gx[G_W-1] ? G_W'(-gx) : G_W'(gx);
  assign ay = gy[G_W-1] ? G_W'(-gy) : G_W'(gy);

  assign l1_sum = {1'b0, ax} + {1'b0, ay};
  assign l1_pix = (|l1_sum[G_W:PIX_W]) ? PIX_MAX : l1_sum[PIX_W-1:0];

  assign ax_w = SQ_W'(ax);
  assign ay_w = SQ_W'(ay);
  assign sq   = ax_w * ax_w + ay_w * ay_w;

  assign sq_start = (state_q == GRAD) && (mode_q != MODE_L1);

  isqrt_seq #(.SQ_W(SQ_W)) u_isqrt (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (sq_start),
    .radicand (sq),
    .done     (sq_done),
    .root     (root)
  );

  assign root_pix = (|root[RT_W-1:PIX_W]) ? PIX_MAX : root[PIX_W-1:0];
  assign sq_pix   = (mode_q == MODE_THR) ? ((root >= RT_W'(thresh_q)) ? PIX_MAX : '0)
                                         : root_pix;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      win_q       <= '0;
      mode_q      <= MODE_SQRT;
      thresh_q    <= '0;
      out_pixel_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          win_q    <= win;
          mode_q   <= mode;
          thresh_q <= thresh;
          state_q  <= GRAD;
        end
        GRAD: if (mode_q == MODE_L1) begin
          out_pixel_q <= l1_pix;
          state_q     <= OUT;
        end else begin
          state_q <= SQRT;
        end
        SQRT: if (sq_done) begin
          out_pixel_q <= sq_pix;
          state_q     <= OUT;
        end
        OUT: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);
  assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_sobel_pipe.sv
// Bench for sobel_pipe at PIX_W=8: directed corner windows, backpressure, mid-run reset, then random traffic.
module tb_sobel_pipe;

  localparam int PIX_W = 8;
  localparam int RT_W  = 11;

  logic        clk;
  logic        n_rst;
  logic [71:0] win;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [7:0]  thresh;
  logic [7:0]  out_pixel;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [71:0] w;
    logic [1:0]  m;
    logic [7:0]  t;
    int          exp;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  sobel_pipe #(.PIX_W(PIX_W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .win       (win),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .thresh    (thresh),
    .out_pixel (out_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: Sobel sums in plain integers, floor root by search.
  function automatic int model(input logic [71:0] w, input logic [1:0] m, input logic [7:0] t);
    int p[9];
    int gx, gy, sq, r, l1;
    for (int k = 0; k < 9; k++) p[k] = int'(w[k*8 +: 8]);
    gx = p[6] + 2*p[7] + p[8] - p[0] - 2*p[1] - p[2];
    gy = p[2] + 2*p[5] + p[8] - p[0] - 2*p[3] - p[6];
    if (m == 2'b01) begin
      l1 = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (l1 > 255) ? 255 : l1;
    end
    sq = gx*gx + gy*gy;
    r = 0;
    while ((r+1)*(r+1) <= sq) r++;
    if (m == 2'b10) return (r >= int'(t)) ? 255 : 0;
    return (r > 255) ? 255 : r;
  endfunction

  function automatic logic [71:0] rand_win(input int maxv);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'($urandom_range(0, maxv));
    return w;
  endfunction

  task automatic do_txn(input string tag, input logic [71:0] w, input logic [1:0] m,
                        input logic [7:0] t, input int exp_pix, input int hold);
    int lat;
    int exp_lat;
    exp_lat = (m == 2'b01) ? 2 : RT_W + 2;
    @(negedge clk);
    check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    win = w; mode = m; thresh = t; in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        win = rand_win(255);
        mode = 2'($urandom);
        thresh = 8'($urandom);
        check({tag, ":busy"}, 32'({in_ready, busy}), 32'b01);
      end
    end while (!out_valid && lat < 100);
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":pixel"}, 32'(out_pixel), 32'(exp_pix));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      win = rand_win(255);
      @(posedge clk); #1;
      check({tag, ":hold"}, 32'({out_valid, in_ready, out_pixel}), 32'({1'b1, 1'b0, 8'(exp_pix)}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":release"}, 32'({out_valid, in_ready, busy}), 32'b010);
  endtask

  initial begin
    logic [71:0] w_flat, w_a, w_b, w_c;
    logic [1:0]  m;
    logic [7:0]  t;
    logic [71:0] w;

    w_flat = {9{8'd100}};
    w_a = '0; w_a[56 +: 8] = 8'd3; w_a[40 +: 8] = 8'd4;
    w_b = '0; w_b[8 +: 8]  = 8'd3; w_b[24 +: 8] = 8'd4;
    w_c = '0; w_c[48 +: 24] = 24'hFFFFFF;

    vecs.push_back('{w_flat, 2'b00, 8'd0,   0,   0});
    vecs.push_back('{w_a,    2'b00, 8'd0,   10,  0});
    vecs.push_back('{w_a,    2'b01, 8'd0,   14,  0});
    vecs.push_back('{w_a,    2'b10, 8'd10,  255, 0});
    vecs.push_back('{w_a,    2'b10, 8'd11,  0,   0});
    vecs.push_back('{w_b,    2'b00, 8'd0,   10,  0});
    vecs.push_back('{w_b,    2'b01, 8'd0,   14,  0});
    vecs.push_back('{w_c,    2'b00, 8'd0,   255, 0});
    vecs.push_back('{w_c,    2'b01, 8'd0,   255, 0});
    vecs.push_back('{w_c,    2'b11, 8'd0,   255, 0});
    vecs.push_back('{w_flat, 2'b10, 8'd0,   255, 0});
    vecs.push_back('{w_flat, 2'b01, 8'd0,   0,   0});
    vecs.push_back('{w_flat, 2'b10, 8'd1,   0,   0});
    vecs.push_back('{w_a,    2'b00, 8'd0,   10,  20});
    vecs.push_back('{w_b,    2'b01, 8'd0,   14,  3});
    vecs.push_back('{w_c,    2'b01, 8'd0,   255, 0});

    n_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    win = '0; mode = 2'b00; thresh = '0;
    #3 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({out_valid, busy, out_pixel}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    n_rst = 1'b1;

    foreach (vecs[i])
      do_txn($sformatf("dir%0d", i), vecs[i].w, vecs[i].m, vecs[i].t, vecs[i].exp, vecs[i].hold);

    // Abort five cycles into the root iteration; out_pixel still holds 255 from the last result.
    @(negedge clk);
    win = w_a; mode = 2'b00; thresh = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd1);
    n_rst = 1'b0;
    #1;
    check("midrst_outputs", 32'({out_valid, busy, in_ready, out_pixel}), 32'({1'b0, 1'b0, 1'b1, 8'd0}));
    @(negedge clk);
    n_rst = 1'b1;
    do_txn("post_rst", w_a, 2'b00, 8'd0, 10, 0);

    for (int i = 0; i < 40; i++) begin
      w = rand_win(($urandom_range(0, 1) == 0) ? 15 : 255);
      m = 2'($urandom);
      t = 8'($urandom_range(0, 100));
      do_txn($sformatf("rnd%0d", i), w, m, t, model(w, m, t), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
